// File: rtl/cambus_deser.sv
// cambus_deser: multi-lane serial camera-bus deserializer with framing lock, error count and vblank stretch
module cambus_deser #(
  parameter int LANES = 2,
  parameter int BITS = 7,
  parameter int VSYNC_IDX = 2,
  parameter int HSYNC_IDX = 4,
  parameter int LOCK_COUNT = 4,
  parameter int VBLANK_STRETCH = 2047,
  parameter int ERR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_valid,
  input  logic                  sync_in,
  input  logic [LANES-1:0]      data_in,
  output logic [LANES*BITS-1:0] pixel,
  output logic                  pixel_valid,
  output logic                  hblank,
  output logic                  vblank,
  output logic                  locked,
  output logic [ERR_W-1:0]      err_count
);
  localparam int TW = VBLANK_STRETCH > 0 ? $clog2(VBLANK_STRETCH + 1) : 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int CW = $clog2(BITS);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t state;
  logic [BITS+1:0] ssr;
  logic [LANES-1:0][BITS+1:0] dsr;
  logic [CW-1:0] bit_cnt;
  logic [GW-1:0] good;
  logic [TW-1:0] timer;
  logic [LANES*BITS-1:0] word;
  logic marker, at1, hsync, vsync, unused;
  // window[i] = shift_reg[i-1], so the completed word window[BITS+1:2] is shift_reg[BITS:1]
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign word[l*BITS +: BITS] = dsr[l][BITS:1];
  end
  assign marker = sync_in & ssr[0] & ~ssr[1];
  assign at1 = bit_cnt == CW'(1);
  assign hsync = ssr[BITS-HSYNC_IDX];
  assign vsync = ssr[BITS-VSYNC_IDX];
  assign unused = ^{ssr, dsr};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      ssr <= '0;
      dsr <= '0;
      bit_cnt <= '0;
      good <= '0;
      timer <= '0;
      pixel <= '0;
      pixel_valid <= 1'b0;
      hblank <= 1'b1;
      vblank <= 1'b0;
      locked <= 1'b0;
      err_count <= '0;
    end else begin
      pixel_valid <= 1'b0;
      if (bit_valid) begin
        ssr <= {ssr[BITS:0], sync_in};
        for (int l = 0; l < LANES; l++) dsr[l] <= {dsr[l][BITS:0], data_in[l]};
        bit_cnt <= bit_cnt == CW'(BITS - 1) ? '0 : bit_cnt + CW'(1);
        case (state)
          HUNT: if (marker) begin
            bit_cnt <= CW'(2);
            good <= GW'(1);
            state <= LOCK_COUNT == 1 ? LOCKED : CHECK;
            locked <= LOCK_COUNT == 1;
          end
          CHECK: if (at1) begin
            if (marker) begin
              good <= good + GW'(1);
              if (good == GW'(LOCK_COUNT - 1)) begin
                state <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              state <= HUNT;
              err_count <= err_count == '1 ? err_count : err_count + ERR_W'(1);
            end
          end
          LOCKED: if (at1) begin
            if (marker) begin
              pixel <= word;
              pixel_valid <= 1'b1;
              hblank <= ~hsync;
              if (vsync) begin
                timer <= TW'(VBLANK_STRETCH);
                vblank <= 1'b1;
              end else if (timer != '0) timer <= timer - TW'(1);
              else vblank <= 1'b0;
            end else begin
              state <= HUNT;
              locked <= 1'b0;
              hblank <= 1'b1;
              err_count <= err_count == '1 ? err_count : err_count + ERR_W'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cambus_deser.sv
// tb_cambus_deser: word-level reference model plus directed checks for cambus_deser
module tb_cambus_deser;
  localparam int B = 7, L = 2, LC = 4, VS = 2047;
  localparam logic [B-1:0] SN = 7'b1100000, SV = 7'b1110000, SH = 7'b1100100, SX = 7'b0000000;
  localparam logic [L*B-1:0] DN = {7'b0101010, 7'b1010101};
  logic clk = 0, rst_n = 0, bit_valid = 0, sync_in = 0;
  logic [L-1:0] data_in = '0;
  logic [L*B-1:0] pixel;
  logic pixel_valid, hblank, vblank, locked;
  logic [7:0] err_count;
  logic bv2 = 0, s2 = 0;
  logic [2:0] d2 = '0;
  logic [23:0] pixel2;
  logic pv2, hblank2, vblank2, locked2;
  logic [7:0] err2;
  cambus_deser u_dut (.clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .sync_in(sync_in),
    .data_in(data_in), .pixel(pixel), .pixel_valid(pixel_valid), .hblank(hblank),
    .vblank(vblank), .locked(locked), .err_count(err_count));
  cambus_deser #(.LANES(3), .BITS(8), .VSYNC_IDX(2), .HSYNC_IDX(4)) u_dut2 (.clk(clk),
    .rst_n(rst_n), .bit_valid(bv2), .sync_in(s2), .data_in(d2), .pixel(pixel2),
    .pixel_valid(pv2), .hblank(hblank2), .vblank(vblank2), .locked(locked2), .err_count(err2));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, emit_cyc = -1, pv_cnt = 0, pv_base;
  int m_run, m_err, m_n;
  bit m_seen, m_last, m_hb, m_vb, chk_en = 0;
  logic [L*B-1:0] m_pix, p_dw;
  logic [B-1:0] p_sw;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_run = 0; m_err = 0; m_n = 0; m_seen = 0; m_last = 0; m_hb = 1; m_vb = 0;
    m_pix = '0; p_sw = '0; p_dw = '0; emit_cyc = -1;
  endtask
  // called at bit 1 of every word: a word opens with a marker iff it starts 1,1 after a 0
  task automatic m_word(input logic [B-1:0] sw);
    bit mk;
    mk = sw[B-1] && sw[B-2] && !m_last;
    if (mk) begin
      if (m_run >= LC) begin
        m_pix = p_dw;
        m_hb = !p_sw[B-1-4];
        if (p_sw[B-1-2]) begin m_seen = 1; m_n = 0; end else m_n++;
        m_vb = m_seen && m_n <= VS;
        emit_cyc = cyc;
      end
      if (m_run < LC) m_run++;
    end else begin
      if (m_run > 0 && m_err < 255) m_err++;
      if (m_run >= LC) m_hb = 1;
      m_run = 0;
    end
  endtask
  always @(negedge clk) begin
    if (pixel_valid) pv_cnt++;
    if (chk_en) begin
      chk("pixel", pixel, m_pix);
      chk("pixel_valid", pixel_valid, emit_cyc == cyc);
      chk("hblank", hblank, m_hb);
      chk("vblank", vblank, m_vb);
      chk("locked", locked, m_run >= LC);
      chk("err_count", err_count, m_err);
    end
  end
  task automatic step(input logic v, input logic s, input logic [L-1:0] d);
    bit_valid = v; sync_in = s; data_in = d;
    @(posedge clk); #1;
    bit_valid = 0;
  endtask
  task automatic send(input logic [B-1:0] sw, input logic [L*B-1:0] dw, input int lo, input int hi, input int gap);
    logic [L-1:0] d;
    for (int k = lo; k <= hi; k++) begin
      for (int l = 0; l < L; l++) d[l] = dw[l*B+B-1-k];
      step(1, sw[B-1-k], d);
      if (k == 1) m_word(sw);
      if (k == B - 1) begin m_last = sw[0]; p_sw = sw; p_dw = dw; end
      repeat ($urandom_range(gap, 0)) step(0, 1'($urandom), L'($urandom));
    end
  endtask
  task automatic word(input logic [B-1:0] sw, input logic [L*B-1:0] dw, input int gap);
    send(sw, dw, 0, B - 1, gap);
  endtask
  task automatic rst_checks(input string tag);
    chk({tag, "_pixel"}, pixel, 0);
    chk({tag, "_pv"}, pixel_valid, 0);
    chk({tag, "_hblank"}, hblank, 1);
    chk({tag, "_vblank"}, vblank, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err_count, 0);
  endtask
  initial begin
    logic [L*B-1:0] r;
    logic [23:0] dd;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_checks("reset");
    chk_en = 1;
    @(negedge clk); #1; rst_n = 1;
    for (int i = 1; i <= 6; i++) begin
      send(SN, DN, 0, 1, 0);
      if (i < 5) chk("no_early_pv", pixel_valid, 0);
      if (i == 3) chk("lock_m3", locked, 0);
      if (i == 4) chk("lock_m4", locked, 1);
      if (i == 5) begin
        chk("first_pv", pixel_valid, 1);
        chk("first_pixel", pixel, 14'h1555);
        chk("first_hblank", hblank, 1);
        chk("first_vblank", vblank, 0);
      end
      send(SN, DN, 2, B - 1, 0);
    end
    send(SX, DN, 0, 1, 0);
    chk("loss_locked", locked, 0);
    chk("loss_err", err_count, 1);
    chk("loss_hblank", hblank, 1);
    send(SX, DN, 2, B - 1, 0);
    pv_base = pv_cnt;
    for (int i = 1; i <= 5; i++) begin
      send(SN, DN, 0, 1, 0);
      if (i == 4) begin
        chk("relock", locked, 1);
        chk("relock_no_pv", pv_cnt - pv_base, 0);
      end
      if (i == 5) chk("relock_pv", pixel_valid, 1);
      send(SN, DN, 2, B - 1, 0);
    end
    word(SV, DN, 0);
    send(SN, DN, 0, 1, 0);
    chk("vsync_vblank", vblank, 1);
    for (int j = 1; j <= 2048; j++) begin
      send(SN, DN, 2, B - 1, 0);
      send(SN, DN, 0, 1, 0);
      if (j == 2047) chk("vblank_2047", vblank, 1);
      if (j == 2048) chk("vblank_2048", vblank, 0);
    end
    send(SN, DN, 2, B - 1, 0);
    word(SH, DN, 0);
    send(SN, DN, 0, 1, 0);
    chk("hsync_hblank", hblank, 0);
    send(SN, DN, 2, B - 1, 0);
    for (int i = 1; i <= 12; i++) begin
      r = (L*B)'($urandom);
      word(i % 5 == 0 ? (SV | SH) : (i % 3 == 0 ? SH : SN), r, 0);
    end
    for (int i = 0; i < 10; i++) word(SN, DN, 5);
    chk("gap_pixel", pixel, 14'h1555);
    for (int i = 0; i < 300; i++) begin
      word(SN, DN, 0);
      word(SX, DN, 0);
    end
    chk("err_sat", err_count, 255);
    for (int i = 0; i < 5; i++) word(SN, DN, 0);
    chk("pre_rst_locked", locked, 1);
    send(SN, DN, 0, 2, 0);
    #2 rst_n = 0;
    #1;
    m_reset();
    rst_checks("async");
    @(negedge clk); #1; rst_n = 1;
    for (int i = 1; i <= 4; i++) begin
      send(SN, DN, 0, 1, 0);
      if (i == 3) chk("post_rst_m3", locked, 0);
      if (i == 4) chk("post_rst_m4", locked, 1);
      send(SN, DN, 2, B - 1, 0);
    end
    dd = 24'hFF3CA5;
    for (int i = 1; i <= 6; i++) begin
      for (int k = 0; k < 8; k++) begin
        bv2 = 1; s2 = k < 2;
        for (int l = 0; l < 3; l++) d2[l] = dd[l*8+7-k];
        @(posedge clk); #1;
        bv2 = 0;
        if (k == 1 && i == 4) chk("p2_locked", locked2, 1);
        if (k == 1 && i >= 5) begin
          chk("p2_pv", pv2, 1);
          chk("p2_pixel", pixel2, 24'hFF3CA5);
          chk("p2_hblank", hblank2, 1);
          chk("p2_vblank", vblank2, 0);
          chk("p2_err", err2, 0);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #900000;
    errors++;
    $display("FAIL timeout actual running required finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
